// File: rtl/mipi_hs_burst_framer.sv
// Single-lane D-PHY transmit byte framer.
// Wraps a valid/ready/last byte stream in one LP->HS->LP lane burst.
module mipi_hs_burst_framer #(
  parameter int         T_LPX     = 2,
  parameter int         T_PREP    = 2,
  parameter int         T_ZERO    = 4,
  parameter int         T_TRAIL   = 2,
  parameter int         T_EXIT    = 3,
  parameter logic [7:0] SYNC_BYTE = 8'hB8
) (
  input  logic       byte_clk,
  input  logic       sys_rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  input  logic       in_last,
  output logic       in_ready,
  output logic [7:0] hs_data,
  output logic       hs_en,
  output logic [1:0] lp_out,
  output logic       busy,
  output logic       underrun
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] LPX   = 3'd1;
  localparam logic [2:0] PREP  = 3'd2;
  localparam logic [2:0] ZERO  = 3'd3;
  localparam logic [2:0] SYNC  = 3'd4;
  localparam logic [2:0] DATA  = 3'd5;
  localparam logic [2:0] TRAIL = 3'd6;
  localparam logic [2:0] EXIT  = 3'd7;

  localparam logic [7:0] LPX_LD   = 8'(T_LPX - 1);
  localparam logic [7:0] PREP_LD  = 8'(T_PREP - 1);
  localparam logic [7:0] ZERO_LD  = 8'(T_ZERO - 1);
  localparam logic [7:0] TRAIL_LD = 8'(T_TRAIL - 1);
  localparam logic [7:0] EXIT_LD  = 8'(T_EXIT - 1);

  logic [2:0] state;
  logic [7:0] cnt;
  logic       last_bit;
  logic [7:0] trail_byte;

  assign in_ready   = (state == DATA);
  assign trail_byte = {8{~last_bit}};

  always_ff @(posedge byte_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      last_bit <= 1'b0;
      hs_data  <= 8'h00;
      hs_en    <= 1'b0;
      lp_out   <= 2'b11;
      busy     <= 1'b0;
      underrun <= 1'b0;
    end else begin
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            state  <= LPX;
            cnt    <= LPX_LD;
            busy   <= 1'b1;
            lp_out <= 2'b01;
          end
        end
        LPX: begin
          if (cnt == 8'd0) begin
            state  <= PREP;
            cnt    <= PREP_LD;
            lp_out <= 2'b00;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        PREP: begin
          if (cnt == 8'd0) begin
            state   <= (T_ZERO == 1) ? SYNC : ZERO;
            cnt     <= ZERO_LD;
            hs_en   <= 1'b1;
            hs_data <= 8'h00;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        // SYNC is the final zero byte; its exit edge puts the
        // sync byte on the wire while DATA is already accepting.
        ZERO: begin
          if (cnt <= 8'd1) begin
            state <= SYNC;
            cnt   <= 8'd0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        SYNC: begin
          state    <= DATA;
          hs_data  <= SYNC_BYTE;
          last_bit <= SYNC_BYTE[7];
        end
        DATA: begin
          if (in_valid) begin
            hs_data  <= in_data;
            last_bit <= in_data[7];
            if (in_last) begin
              // one extra count: the final byte is still on the wire
              state <= TRAIL;
              cnt   <= 8'(T_TRAIL);
            end
          end else begin
            underrun <= 1'b1;
            state    <= TRAIL;
            cnt      <= TRAIL_LD;
            hs_data  <= trail_byte;
          end
        end
        TRAIL: begin
          if (cnt == 8'd0) begin
            state   <= EXIT;
            cnt     <= EXIT_LD;
            hs_en   <= 1'b0;
            hs_data <= 8'h00;
            lp_out  <= 2'b11;
          end else begin
            cnt     <= cnt - 8'd1;
            hs_data <= trail_byte;
          end
        end
        EXIT: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mipi_hs_burst_framer.sv
// Directed bench for mipi_hs_burst_framer.
// Per-cycle output words are compared against hand-derived tables.
module tb_mipi_hs_burst_framer;

  logic       byte_clk = 1'b0;
  logic       sys_rst_n;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_last;
  logic       in_ready;
  logic [7:0] hs_data;
  logic       hs_en;
  logic [1:0] lp_out;
  logic       busy;
  logic       underrun;

  mipi_hs_burst_framer dut (
    .byte_clk (byte_clk),
    .sys_rst_n(sys_rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_last  (in_last),
    .in_ready (in_ready),
    .hs_data  (hs_data),
    .hs_en    (hs_en),
    .lp_out   (lp_out),
    .busy     (busy),
    .underrun (underrun)
  );

  always #5 byte_clk = ~byte_clk;

  int n_checks = 0;
  int n_err    = 0;

  // word = {underrun, lp_out[1:0], hs_en, busy, hs_data[7:0]}
  logic [12:0] obs_q[$];
  logic [7:0]  hs_q[$];
  logic [7:0]  pl[8];
  logic        lm[8];
  int          idx, nacc, nrdy, nur;

  int e1[20] = '{'h500, 'h500, 'h100, 'h100, 'h300, 'h300, 'h300,
                 'h300, 'h3B8, 'h329, 'h305, 'h380, 'h300, 'h300,
                 'hD00, 'hD00, 'hD00, 'hC00, 'hC00, 'hC00};
  int e2[16] = '{'h500, 'h500, 'h100, 'h100, 'h300, 'h300, 'h300,
                 'h300, 'h3B8, 'h305, 'h3FF, 'h3FF, 'hD00, 'hD00,
                 'hD00, 'hC00};
  int e3a[16] = '{'h500, 'h500, 'h100, 'h100, 'h300, 'h300, 'h300,
                  'h300, 'h3B8, 'h391, 'h1300, 'h300, 'hD00, 'hD00,
                  'hD00, 'hC00};
  int e3b[16] = '{'h500, 'h500, 'h100, 'h100, 'h300, 'h300, 'h300,
                  'h300, 'h3B8, 'h311, 'h13FF, 'h3FF, 'hD00, 'hD00,
                  'hD00, 'hC00};
  int e5[34] = '{'h500, 'h500, 'h100, 'h100, 'h300, 'h300, 'h300,
                 'h300, 'h3B8, 'h305, 'h3FF, 'h3FF, 'hD00, 'hD00,
                 'hD00, 'hC00, 'h500, 'h500, 'h100, 'h100, 'h300,
                 'h300, 'h300, 'h300, 'h3B8, 'h329, 'h3FF, 'h3FF,
                 'hD00, 'hD00, 'hD00, 'hC00, 'hC00, 'hC00};
  int elb[4] = '{'hB8, 'h29, 'h05, 'h80};

  function automatic logic [12:0] obs();
    return {underrun, lp_out, hs_en, busy, hs_data};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] c, input logic la,
                      input logic lb, input logic lc);
    pl[0] = a; pl[1] = b; pl[2] = c;
    lm[0] = la; lm[1] = lb; lm[2] = lc;
  endtask

  task automatic drive(input int n);
    in_valid = (idx < n);
    in_data  = (idx < n) ? pl[idx] : 8'h00;
    in_last  = (idx < n) ? lm[idx] : 1'b0;
  endtask

  // called at a negedge; logs the outputs after each of cyc edges
  task automatic run(input int n, input int cyc);
    logic acc;
    idx = 0; nacc = 0; nrdy = 0; nur = 0;
    obs_q.delete();
    hs_q.delete();
    drive(n);
    for (int c = 0; c < cyc; c++) begin
      acc = in_valid && in_ready;
      if (in_ready) nrdy++;
      @(negedge byte_clk);
      if (acc) begin
        idx++;
        nacc++;
      end
      obs_q.push_back(obs());
      if (hs_en) hs_q.push_back(hs_data);
      if (underrun) nur++;
      drive(n);
    end
  endtask

  task automatic cmp_tab(input string tag, input int exp[], input int len);
    for (int k = 0; k < len; k++)
      chk($sformatf("%s[%0d]", tag, k), 32'(obs_q[k]), 32'(exp[k]));
  endtask

  task automatic loopback();
    logic       bits[$];
    logic [7:0] got[$];
    logic [7:0] sr;
    logic       found;
    int         c8;
    for (int s = 0; s < 8; s++) begin
      bits.delete();
      got.delete();
      repeat (s) bits.push_back(1'b0);
      foreach (hs_q[i])
        for (int b = 0; b < 8; b++) bits.push_back(hs_q[i][b]);
      sr = 8'h00; found = 1'b0; c8 = 0;
      foreach (bits[j]) begin
        sr = {bits[j], sr[7:1]};
        if (!found) begin
          if (j >= 7 && sr == 8'hB8) begin
            found = 1'b1;
            got.push_back(sr);
            c8 = 0;
          end
        end else begin
          c8++;
          if (c8 == 8) begin
            got.push_back(sr);
            c8 = 0;
          end
        end
      end
      chk($sformatf("lb_found_s%0d", s), 32'(found), 32'd1);
      chk($sformatf("lb_len_s%0d", s), 32'(got.size() >= 4), 32'd1);
      for (int k = 0; k < 4; k++)
        if (k < got.size())
          chk($sformatf("lb_s%0d_b%0d", s, k), 32'(got[k]), 32'(elb[k]));
    end
  endtask

  initial begin
    sys_rst_n = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    repeat (3) @(negedge byte_clk);
    chk("rst_obs", 32'(obs()), 32'h0C00);
    chk("rst_rdy", 32'(in_ready), 32'd0);
    sys_rst_n = 1'b1;
    @(negedge byte_clk);

    // three-byte burst
    load(8'h29, 8'h05, 8'h80, 1'b0, 1'b0, 1'b1);
    run(3, 20);
    cmp_tab("t1", e1, 20);
    chk("t1_acc", 32'(nacc), 32'd3);
    chk("t1_rdy", 32'(nrdy), 32'd3);
    chk("t1_ur", 32'(nur), 32'd0);
    chk("t1_hslen", 32'(hs_q.size()), 32'd10);
    loopback();

    // single byte, bit7=0 -> FF trailer
    load(8'h05, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
    run(1, 16);
    cmp_tab("t2", e2, 16);
    chk("t2_ur", 32'(nur), 32'd0);
    chk("t2_acc", 32'(nacc), 32'd1);

    // underrun after 0x91 -> 00 trailer
    load(8'h91, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run(1, 16);
    cmp_tab("t3a", e3a, 16);
    chk("t3a_ur", 32'(nur), 32'd1);

    // underrun after 0x11 -> FF trailer
    load(8'h11, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
    run(1, 16);
    cmp_tab("t3b", e3b, 16);
    chk("t3b_ur", 32'(nur), 32'd1);

    // valid held high across two bursts
    load(8'h05, 8'h29, 8'h00, 1'b1, 1'b1, 1'b0);
    run(2, 34);
    cmp_tab("t5", e5, 34);
    chk("t5_acc", 32'(nacc), 32'd2);
    chk("t5_ur", 32'(nur), 32'd0);

    // async reset mid-DATA
    load(8'h29, 8'h05, 8'h80, 1'b0, 1'b0, 1'b1);
    run(3, 10);
    chk("t4_pre", 32'(obs_q[9]), 32'h0329);
    sys_rst_n = 1'b0;
    #1;
    chk("t4_rst_obs", 32'(obs()), 32'h0C00);
    chk("t4_rst_rdy", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge byte_clk);
    sys_rst_n = 1'b1;
    @(negedge byte_clk);
    run(3, 20);
    cmp_tab("t4", e1, 20);
    chk("t4_acc", 32'(nacc), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
